// File: rtl/dshot_pkg.sv
// Shared DShot frame layout, decoded-output record and CRC helper.
package dshot_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned THR_MSB    = 15;
    localparam int unsigned THR_LSB    = 5;
    localparam int unsigned TELEM      = 4;
    localparam int unsigned CRC_MSB    = 3;
    localparam int unsigned CMD_MAX    = 47;

    localparam int unsigned THR_W   = THR_MSB - THR_LSB + 1;
    localparam int unsigned CRC_W   = CRC_MSB + 1;
    localparam int unsigned SPEED_W = 8;
    localparam int unsigned CMD_W   = 6;

    typedef struct packed {
        logic [SPEED_W-1:0] speed;
        logic [CMD_W-1:0]   cmd;
        logic               is_cmd;
        logic               crc_ok;
        logic               valid_speed;
        logic               telem;
    } speed_out_t;

    // XOR of the three nibbles covering throttle and telemetry.
    function automatic logic [CRC_W-1:0] dshot_crc(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

endpackage

// File: rtl/dshot_bit_timer.sv
// Synchronizes the DShot line, times each high pulse and reports bits,
// line faults and inter-frame low timeouts as single-cycle pulses.
module dshot_bit_timer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned GLITCH_CYCLES   = 8,
    parameter int unsigned BIT_THRESHOLD   = 60,
    parameter int unsigned MAX_HIGH_CYCLES = 120,
    parameter int unsigned FRAME_TIMEOUT   = 240
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dshot_pin,
    output logic line_rise,
    output logic bit_valid,
    output logic bit_value,
    output logic frame_abort
);

    localparam int unsigned HW = $clog2(MAX_HIGH_CYCLES + 2);
    localparam int unsigned LW = $clog2(FRAME_TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [HW-1:0]          high_cnt_q, high_cnt_d;
    logic [LW-1:0]          low_cnt_q, low_cnt_d;
    logic                   line_rise_q, line_rise_d;
    logic                   bit_valid_q, bit_valid_d;
    logic                   bit_value_q, bit_value_d;
    logic                   frame_abort_q, frame_abort_d;
    logic                   line, rise, fall, timeout;

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], dshot_pin};
        line          = sync_q[SYNC_STAGES-1];
        prev_d        = line;
        rise          = line & ~prev_q;
        fall          = ~line & prev_q;
        high_cnt_d    = '0;
        low_cnt_d     = '0;
        timeout       = 1'b0;

        // High width counts the first high cycle as 1 and saturates past the fault limit.
        if (line) begin
            if (rise)
                high_cnt_d = HW'(1);
            else if (high_cnt_q == HW'(MAX_HIGH_CYCLES + 1))
                high_cnt_d = high_cnt_q;
            else
                high_cnt_d = high_cnt_q + HW'(1);
        end else begin
            timeout   = (low_cnt_q == LW'(FRAME_TIMEOUT - 1));
            low_cnt_d = (low_cnt_q == LW'(FRAME_TIMEOUT)) ? low_cnt_q : low_cnt_q + LW'(1);
        end

        line_rise_d   = rise;
        bit_valid_d   = fall && (high_cnt_q >= HW'(GLITCH_CYCLES))
                             && (high_cnt_q <= HW'(MAX_HIGH_CYCLES));
        bit_value_d   = (high_cnt_q >= HW'(BIT_THRESHOLD));
        frame_abort_d = (fall && (high_cnt_q > HW'(MAX_HIGH_CYCLES))) || timeout;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q        <= '0;
            prev_q        <= 1'b0;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            line_rise_q   <= 1'b0;
            bit_valid_q   <= 1'b0;
            bit_value_q   <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            line_rise_q   <= line_rise_d;
            bit_valid_q   <= bit_valid_d;
            bit_value_q   <= bit_value_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign line_rise   = line_rise_q;
    assign bit_valid   = bit_valid_q;
    assign bit_value   = bit_value_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: rtl/speed_handler.sv
// DShot150 receiver: assembles 16-bit frames, checks CRC and publishes
// motor speed, special-command code and status flags.
module speed_handler
    import dshot_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned GLITCH_CYCLES   = 8,
    parameter int unsigned BIT_THRESHOLD   = 60,
    parameter int unsigned MAX_HIGH_CYCLES = 120,
    parameter int unsigned FRAME_TIMEOUT   = 240
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dshotPin,
    output logic [SPEED_W-1:0] outputSpeed,
    output logic [CMD_W-1:0]   specialCommand,
    output logic               isSpecialCommand,
    output logic               CRCValid,
    output logic               processing,
    output logic               isValidSpeed,
    output logic               telemetryBit
);

    localparam int unsigned BCW = $clog2(FRAME_BITS);

    logic                  line_rise, bit_valid, bit_value, frame_abort;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-2:0] shift_q, shift_d;
    logic                  processing_q, processing_d;
    speed_out_t            out_q, out_d;
    logic [FRAME_BITS-1:0] frame_w;
    logic [THR_W-1:0]      throttle;
    logic                  crc_ok;

    dshot_bit_timer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .GLITCH_CYCLES   (GLITCH_CYCLES),
        .BIT_THRESHOLD   (BIT_THRESHOLD),
        .MAX_HIGH_CYCLES (MAX_HIGH_CYCLES),
        .FRAME_TIMEOUT   (FRAME_TIMEOUT)
    ) u_bit_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .dshot_pin   (dshotPin),
        .line_rise   (line_rise),
        .bit_valid   (bit_valid),
        .bit_value   (bit_value),
        .frame_abort (frame_abort)
    );

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        processing_d = processing_q;
        out_d        = out_q;
        frame_w      = {shift_q, bit_value};
        throttle     = frame_w[THR_MSB:THR_LSB];
        crc_ok       = (dshot_crc(frame_w[THR_MSB:TELEM]) == frame_w[CRC_MSB:0]);

        if (frame_abort) begin
            bit_cnt_d    = '0;
            shift_d      = '0;
            processing_d = 1'b0;
        end else if (bit_valid) begin
            shift_d      = frame_w[FRAME_BITS-2:0];
            processing_d = 1'b1;
            if (bit_cnt_q == BCW'(FRAME_BITS - 1)) begin
                bit_cnt_d    = '0;
                processing_d = 1'b0;
                out_d.crc_ok = crc_ok;
                // Accepted frame: zero throttle, command range, or real speed.
                if (crc_ok) begin
                    out_d.telem = frame_w[TELEM];
                    if (throttle == '0) begin
                        out_d.speed       = '0;
                        out_d.valid_speed = 1'b1;
                        out_d.is_cmd      = 1'b0;
                    end else if (throttle <= THR_W'(CMD_MAX)) begin
                        out_d.cmd         = throttle[CMD_W-1:0];
                        out_d.is_cmd      = 1'b1;
                        out_d.valid_speed = 1'b0;
                    end else begin
                        out_d.speed       = throttle[THR_W-1:THR_W-SPEED_W];
                        out_d.valid_speed = 1'b1;
                        out_d.is_cmd      = 1'b0;
                    end
                end
            end else begin
                bit_cnt_d = bit_cnt_q + BCW'(1);
            end
        end else if (line_rise) begin
            processing_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            processing_q <= 1'b0;
            out_q        <= '0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            processing_q <= processing_d;
            out_q        <= out_d;
        end
    end

    assign outputSpeed      = out_q.speed;
    assign specialCommand   = out_q.cmd;
    assign isSpecialCommand = out_q.is_cmd;
    assign CRCValid         = out_q.crc_ok;
    assign isValidSpeed     = out_q.valid_speed;
    assign telemetryBit     = out_q.telem;
    assign processing       = processing_q;

endmodule

// File: tb/tb_speed_handler.sv
// Scoreboard bench for speed_handler: directed DShot150 frames with
// hand-computed expected outputs, checked whenever a frame ends.
`timescale 1ns/1ps
module tb_speed_handler;

    typedef struct packed {
        logic [7:0] speed;
        logic [5:0] cmd;
        logic       is_cmd;
        logic       crc_ok;
        logic       valid;
        logic       telem;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       dshotPin;
    logic [7:0] outputSpeed;
    logic [5:0] specialCommand;
    logic       isSpecialCommand;
    logic       CRCValid;
    logic       processing;
    logic       isValidSpeed;
    logic       telemetryBit;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_proc = 1'b0;

    speed_handler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dshotPin         (dshotPin),
        .outputSpeed      (outputSpeed),
        .specialCommand   (specialCommand),
        .isSpecialCommand (isSpecialCommand),
        .CRCValid         (CRCValid),
        .processing       (processing),
        .isValidSpeed     (isValidSpeed),
        .telemetryBit     (telemetryBit)
    );

    initial clk = 1'b0;
    always #31 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".outputSpeed"},      32'(outputSpeed),      32'(e.speed));
        check({tag, ".specialCommand"},   32'(specialCommand),   32'(e.cmd));
        check({tag, ".isSpecialCommand"}, 32'(isSpecialCommand), 32'(e.is_cmd));
        check({tag, ".CRCValid"},         32'(CRCValid),         32'(e.crc_ok));
        check({tag, ".isValidSpeed"},     32'(isValidSpeed),     32'(e.valid));
        check({tag, ".telemetryBit"},     32'(telemetryBit),     32'(e.telem));
    endtask

    // Monitor: every end of reception (processing falling) pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (prev_proc && !processing) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame_end actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                check_outputs("frame", e);
            end
        end
        prev_proc = processing;
    end

    task automatic send_bit(input logic b);
        dshotPin = 1'b1;
        repeat (b ? 80 : 40) @(negedge clk);
        dshotPin = 1'b0;
        repeat (b ? 27 : 67) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] f, input exp_t e);
        exp_q.push_back(e);
        for (int i = 15; i >= 0; i--) send_bit(f[i]);
    endtask

    initial begin
        exp_t zero;
        zero     = '0;
        rst_n    = 1'b0;
        dshotPin = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs("reset", zero);
        check("reset.processing", 32'(processing), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Line stuck high 105 us, then low 100 us: fault, no output change.
        exp_q.push_back(zero);
        dshotPin = 1'b1;
        repeat (100) @(negedge clk);
        check("stuck_high.processing", 32'(processing), 32'd1);
        repeat (1580) @(negedge clk);
        dshotPin = 1'b0;
        repeat (1600) @(negedge clk);
        check("stuck_high.processing_after", 32'(processing), 32'd0);

        send_frame(16'hDEA9, exp_t'{8'hDE, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        send_frame(16'hFFEE, exp_t'{8'hFF, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0});

        // Six bits then 140 us low: partial frame dropped silently.
        exp_q.push_back(exp_t'{8'hFF, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        repeat (2240) @(negedge clk);

        send_frame(16'hDEA9, exp_t'{8'hDE, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0});
        send_frame(16'h00AA, exp_t'{8'hDE, 6'd5,  1'b1, 1'b1, 1'b0, 1'b0});
        send_frame(16'hDEA8, exp_t'{8'hDE, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0});
        send_frame(16'h0011, exp_t'{8'h00, 6'd5,  1'b0, 1'b1, 1'b1, 1'b1});
        send_frame(16'h05EB, exp_t'{8'h00, 6'd47, 1'b1, 1'b1, 1'b0, 1'b0});
        send_frame(16'h0606, exp_t'{8'h06, 6'd47, 1'b0, 1'b1, 1'b1, 1'b0});
        send_frame(16'h00AB, exp_t'{8'h06, 6'd47, 1'b0, 1'b0, 1'b1, 1'b0});

        // Reset in the middle of a frame, then a clean frame.
        for (int i = 15; i >= 8; i--) send_bit(1'b1);
        exp_q.push_back(zero);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("mid_reset", zero);
        check("mid_reset.processing", 32'(processing), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(16'hDEA9, exp_t'{8'hDE, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0});

        repeat (300) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("final.processing", 32'(processing), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
